data_bus_demux: RTL
===================

// Module: data_bus_demux
// PURPOSE
//   Parametrised 1-to-NUM_TGT data-bus demultiplexer; successor to the fixed 2-way mem/periph split.
//   Sits between the core data port and the memory/peripheral targets.
//   Decodes the top address bits into a target index and adds a req/gnt handshake.
//   Tracks up to MAX_OUTST outstanding transactions so in-order responses return on data_rvalid_o.
// PARAMETERS
//   NUM_TGT    2   number of targets; index 0 = data memory, 1 = peripherals (default map)
//   ADDR_W     14  byte address width of data_addr_i
//   DATA_W     32  data width; BE_W = DATA_W/8
//   MAX_OUTST  2   max in-flight transactions (>=1); counter width CNT_W = $clog2(MAX_OUTST+1)
//   SEL_W      derived = (NUM_TGT>1) ? $clog2(NUM_TGT) : 1; select = data_addr_i[ADDR_W-1 -: SEL_W]
// PORTS
//   clk_i          in   1               clock, all state on rising edge
//   rst_ni         in   1               reset, synchronous, active-low
//   data_req_i     in   1               core request
//   data_gnt_o     out  1               request accepted this cycle
//   data_we_i      in   1               1 = write
//   data_be_i      in   BE_W            byte enables
//   data_addr_i    in   ADDR_W          byte address
//   data_wdata_i   in   DATA_W          write data
//   data_rvalid_o  out  1               response valid (reads and writes)
//   data_rdata_o   out  DATA_W          response data
//   data_err_o     out  1               response is a decode error (0 when DECERR disabled)
//   tgt_req_o      out  NUM_TGT         one-hot request to selected target
//   tgt_gnt_i      in   NUM_TGT         per-target grant
//   tgt_we_o/tgt_be_o/tgt_wdata_o  out  1/BE_W/DATA_W  broadcast copies of core fields
//   tgt_addr_o     out  ADDR_W-SEL_W    address with select bits stripped
//   tgt_rvalid_i   in   NUM_TGT         per-target response valid
//   tgt_rdata_i    in   NUM_TGT*DATA_W  packed per-target read data, target k at [k*DATA_W +: DATA_W]
// BEHAVIOUR
//   - Reset (rst_ni=0 at posedge): cnt=0, cur_tgt=0, err_pend=0.
//     All outputs then 0: gnt, rvalid, err, rdata, tgt_req.
//   - States: IDLE (cnt==0), BUSY (cnt>0); cur_tgt holds the target of all in-flight transactions.
//   - Issue allowed: ok = (cnt<MAX_OUTST) & (cnt==0 | sel==cur_tgt).
//     A different target stalls until drained, which guarantees in-order responses.
//   - tgt_req_o[sel] = data_req_i & ok (combinational); data_gnt_o = tgt_req_o[sel] & tgt_gnt_i[sel].
//   - On grant: cnt+1, cur_tgt<=sel. On rvalid from cur_tgt with cnt>0: cnt-1.
//     Both in the same cycle: cnt unchanged. IDLE->BUSY on grant; BUSY->IDLE when cnt hits 0.
//   - data_rvalid_o = tgt_rvalid_i[cur_tgt] & (cnt>0); rdata muxed from cur_tgt, else 0.
//     Zero added latency; no same-cycle response to a same-cycle grant.
//   - Spurious rvalid (cnt==0 or non-current target) is ignored; cnt never underflows.
//   - Reset mid-operation drops all pending responses; later target rvalids are spurious.
//   - Targets must answer in order and hold no more than MAX_OUTST transactions.
// CONFIGURATION
//   DATA_BUS_DECERR_EN defined:
//     - sel >= NUM_TGT is unmapped and tracked as pseudo-target NUM_TGT; no tgt_req_o asserted.
//     - Granted when ok. Exactly 1 cycle after grant: rvalid=1, err=1, rdata=0. Writes are dropped.
//     - Back-to-back unmapped requests are allowed up to MAX_OUTST.
//   Not defined:
//     - Unmapped sel aliases to target NUM_TGT-1.
//     - data_err_o tied 0; no pseudo-target logic.
// STRUCTURE
//   - data_bus_pkg: ADDR_W/DATA_W defaults, target index localparams TGT_MEM=0 and TGT_PERIPH=1,
//     and a function sel_of(addr).
//   - Sub-module data_bus_outst_ctr (cnt, cur_tgt, ok, inc/dec, saturation checks).
//     The top level keeps decode and the muxes.
// TESTING
//   1 NUM_TGT=2: read @0x0004, mem rvalid 1 cycle later with 0xDEADBEEF
//     -> gnt same cycle, rvalid+rdata=0xDEADBEEF, err=0.
//   2 Write @0x2010 while a mem read is outstanding
//     -> gnt=0 and tgt_req_o=0 until mem rvalid; then tgt_req_o=2'b10, tgt_addr_o=0x0010.
//   3 MAX_OUTST=2: three back-to-back mem reads, target gnt always 1
//     -> 3rd held until first rvalid; cnt never exceeds 2.
//   4 Simultaneous grant and rvalid on the same target -> cnt unchanged; no lost response.
//   5 NUM_TGT=3 with DECERR_EN: read @0x3000 -> gnt, next cycle rvalid=1, err=1, rdata=0.
//     Without the macro -> routed to target 2.
//   6 rst_ni=0 with cnt=2, then stray tgt_rvalid_i=1 -> all outputs 0, data_rvalid_o stays 0.

Source files
------------

// File: rtl/data_bus_pkg.sv
// Shared defaults, target index map and address-select helper for the data-bus demux.
package data_bus_pkg;
  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 32;
  localparam int TGT_MEM    = 0;
  localparam int TGT_PERIPH = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } outst_state_e;

  // Top sel_w bits of an addr_w-bit byte address, zero-extended to 32 bits.
  function automatic logic [31:0] sel_of(input logic [31:0] addr, input int addr_w,
                                         input int sel_w);
    logic [31:0] mask;
    mask = (32'd1 << sel_w) - 32'd1;
    return (addr >> (addr_w - sel_w)) & mask;
  endfunction
endpackage

// File: rtl/data_bus_outst_ctr.sv
// Outstanding-transaction tracker: counts in-flight requests and pins them to one target.
// Latency: ok_o is combinational from tgt_i; count and current target update on the clock edge.
// Backpressure: ok_o drops when full, or when a different target is requested while busy.
module data_bus_outst_ctr
  import data_bus_pkg::*;
#(
  parameter int TGT_W     = 2,
  parameter int MAX_OUTST = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [TGT_W-1:0] tgt_i,
  input  logic             inc_i,
  input  logic             rsp_i,
  output logic             ok_o,
  output logic             busy_o,
  output logic [TGT_W-1:0] cur_tgt_o
);
  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  outst_state_e     state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [TGT_W-1:0] cur_tgt_q;
  logic             dec;

  assign busy_o    = (state_q == ST_BUSY);
  assign cur_tgt_o = cur_tgt_q;
  // A response with nothing in flight is stray and must not underflow the count.
  assign dec       = rsp_i & busy_o;
  assign ok_o      = (cnt_q < CNT_W'(MAX_OUTST)) & (~busy_o | (tgt_i == cur_tgt_q));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cur_tgt_q <= TGT_W'(TGT_MEM);
    end else begin
      if (inc_i) cur_tgt_q <= tgt_i;
      unique case ({inc_i, dec})
        2'b10: begin
          cnt_q   <= cnt_q + CNT_W'(1);
          state_q <= ST_BUSY;
        end
        2'b01: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= ST_IDLE;
        end
        default: ;
      endcase
    end
  end

  assert property (@(posedge clk_i) disable iff (!rst_ni) cnt_q <= CNT_W'(MAX_OUTST));
  assert property (@(posedge clk_i) disable iff (!rst_ni) inc_i |-> ok_o);
  assert property (@(posedge clk_i) disable iff (!rst_ni) busy_o == (cnt_q != '0));
endmodule

// File: rtl/data_bus_demux.sv
// 1-to-NUM_TGT data-bus demux with in-order response tracking; DATA_BUS_DECERR_EN adds a decode-error pseudo-target.
// Latency: req/gnt combinational, responses forwarded with zero added latency (decode errors answer 1 cycle after grant).
// Backpressure: data_gnt_o held low while the tracker is full or a different target is still draining.
module data_bus_demux
  import data_bus_pkg::*;
#(
  parameter int  NUM_TGT   = 2,
  parameter int  ADDR_W    = ADDR_W_DEF,
  parameter int  DATA_W    = DATA_W_DEF,
  parameter int  MAX_OUTST = 2,
  localparam int BE_W      = DATA_W / 8,
  localparam int SEL_W     = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      data_req_i,
  output logic                      data_gnt_o,
  input  logic                      data_we_i,
  input  logic [BE_W-1:0]           data_be_i,
  input  logic [ADDR_W-1:0]         data_addr_i,
  input  logic [DATA_W-1:0]         data_wdata_i,
  output logic                      data_rvalid_o,
  output logic [DATA_W-1:0]         data_rdata_o,
  output logic                      data_err_o,
  output logic [NUM_TGT-1:0]        tgt_req_o,
  input  logic [NUM_TGT-1:0]        tgt_gnt_i,
  output logic                      tgt_we_o,
  output logic [BE_W-1:0]           tgt_be_o,
  output logic [DATA_W-1:0]         tgt_wdata_o,
  output logic [ADDR_W-SEL_W-1:0]   tgt_addr_o,
  input  logic [NUM_TGT-1:0]        tgt_rvalid_i,
  input  logic [NUM_TGT*DATA_W-1:0] tgt_rdata_i
);
  // One extra index value so the decode-error pseudo-target can be tracked like a real one.
  localparam int TGT_W = $clog2(NUM_TGT + 1);

  logic [31:0]       sel;
  logic              unmapped;
  logic [TGT_W-1:0]  tgt;
  logic [TGT_W-1:0]  cur_tgt;
  logic              ok;
  logic              busy;
  logic              rsp_cur;
  logic [DATA_W-1:0] rdata_cur;

  assign sel      = sel_of(32'(data_addr_i), ADDR_W, SEL_W);
  assign unmapped = (sel >= 32'(NUM_TGT));

`ifdef DATA_BUS_DECERR_EN
  logic err_pend;
  assign tgt = unmapped ? TGT_W'(NUM_TGT) : TGT_W'(sel);
`else
  assign tgt = unmapped ? TGT_W'(NUM_TGT - 1) : TGT_W'(sel);
`endif

  assign tgt_we_o    = data_we_i;
  assign tgt_be_o    = data_be_i;
  assign tgt_wdata_o = data_wdata_i;
  assign tgt_addr_o  = data_addr_i[ADDR_W-SEL_W-1:0];

  always_comb begin
    tgt_req_o = '0;
    for (int k = 0; k < NUM_TGT; k++) begin
      if (tgt == TGT_W'(k)) tgt_req_o[k] = data_req_i & ok;
    end
  end

`ifdef DATA_BUS_DECERR_EN
  assign data_gnt_o = (|(tgt_req_o & tgt_gnt_i)) | (data_req_i & ok & unmapped);
`else
  assign data_gnt_o = |(tgt_req_o & tgt_gnt_i);
`endif

  always_comb begin
    rsp_cur   = 1'b0;
    rdata_cur = '0;
    for (int k = 0; k < NUM_TGT; k++) begin
      if (cur_tgt == TGT_W'(k)) begin
        rsp_cur   = tgt_rvalid_i[k];
        rdata_cur = tgt_rdata_i[k*DATA_W +: DATA_W];
      end
    end
`ifdef DATA_BUS_DECERR_EN
    if (cur_tgt == TGT_W'(NUM_TGT)) rsp_cur = err_pend;
`endif
  end

`ifdef DATA_BUS_DECERR_EN
  // Unmapped accesses answer exactly one cycle after their grant; writes go nowhere.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) err_pend <= 1'b0;
    else         err_pend <= data_gnt_o & unmapped;
  end
  assign data_err_o = data_rvalid_o & (cur_tgt == TGT_W'(NUM_TGT));
`else
  assign data_err_o = 1'b0;
`endif

  assign data_rvalid_o = rsp_cur & busy;
  assign data_rdata_o  = data_rvalid_o ? rdata_cur : '0;

  data_bus_outst_ctr #(
    .TGT_W    (TGT_W),
    .MAX_OUTST(MAX_OUTST)
  ) u_ctr (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .tgt_i    (tgt),
    .inc_i    (data_gnt_o),
    .rsp_i    (rsp_cur),
    .ok_o     (ok),
    .busy_o   (busy),
    .cur_tgt_o(cur_tgt)
  );
endmodule
